// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle for the async FIFO write pointer block.
// Carries the user request, the synchronized read pointer, the address and the status flags.
interface wptr_full_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic                  winc;
  logic [PW-1:0]         wq2_rptr;
  logic                  wovf_clr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PW-1:0]         wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [PW-1:0]         wlevel;
  logic                  wovf;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side pointer: binary address, Gray pointer, and full / almost-full /
// level / sticky overflow status against the read pointer synchronized into this domain.
module wptr_full_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input logic             clk,
  input logic             rst,
  wptr_full_ctrl_if.slave bus
);
  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] rbin_c;
  logic          wacc_c;
  logic          wovf_set_c;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of bits above and at i.
  always_comb begin
    rbin_c = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_c[i] = ^(bus.wq2_rptr >> i);
    end
  end

  always_comb begin
    wacc_c     = bus.winc & ~wfull_q;
    wovf_set_c = bus.winc & wfull_q;
    wbin_d     = wbin_q + PW'(wacc_c);
    wptr_d     = (wbin_d >> 1) ^ wbin_d;
    wlevel_d   = wbin_d - rbin_c;
    // Full when the next write pointer has lapped the read pointer by exactly one depth.
    wfull_d    = (wptr_d == {~bus.wq2_rptr[PW-1 -: 2], bus.wq2_rptr[PW-3:0]});
    wafull_d   = (wlevel_d >= PW'(AFULL_THRESH));
    wovf_d     = bus.wovf_clr ? wovf_set_c : (wovf_q | wovf_set_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wovf         = wovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed plan followed by random traffic, checked each cycle
// against an occupancy model built from integer write/read counts.
module tb_wptr_full_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;
  localparam int TH    = 12;

  logic clk;
  logic rst;

  wptr_full_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  wptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes and the read count the bench presents.
  int wr, rd, lvl_m, prev_wptr;
  bit full_m, afull_m, ovf_m;

  function automatic int gray(input int b);
    int v;
    v = b % MOD;
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("waddr", int'(bus.waddr), wr % DEPTH);
    chk("wptr", int'(bus.wptr), gray(wr));
    chk("wfull", int'(bus.wfull), int'(full_m));
    chk("walmost_full", int'(bus.walmost_full), int'(afull_m));
    chk("wlevel", int'(bus.wlevel), lvl_m);
    chk("wovf", int'(bus.wovf), int'(ovf_m));
    chk("gray_one_bit", int'($countones(5'(prev_wptr) ^ bus.wptr) <= 1), 1);
    prev_wptr = int'(bus.wptr);
  endtask

  task automatic model_reset();
    wr = 0; rd = 0; lvl_m = 0; prev_wptr = 0;
    full_m = 1'b0; afull_m = 1'b0; ovf_m = 1'b0;
  endtask

  task automatic cycle(input bit w, input bit c);
    bit acc;
    bus.winc     = w;
    bus.wovf_clr = c;
    bus.wq2_rptr = 5'(gray(rd));
    @(posedge clk);
    acc   = w && !full_m;
    ovf_m = c ? (w && full_m) : (ovf_m || (w && full_m));
    wr    = wr + int'(acc);
    lvl_m = (wr - rd) % MOD;
    full_m  = (lvl_m == DEPTH);
    afull_m = (lvl_m >= TH);
    #1;
    check_all();
  endtask

  // Reset pulse placed entirely inside the clock-low phase; outputs must clear without an edge.
  task automatic async_reset_pulse();
    @(negedge clk);
    bus.winc = 1'b0;
    bus.wovf_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_waddr", int'(bus.waddr), 0);
    chk("async_rst_wptr", int'(bus.wptr), 0);
    chk("async_rst_wfull", int'(bus.wfull), 0);
    chk("async_rst_wlevel", int'(bus.wlevel), 0);
    chk("async_rst_wovf", int'(bus.wovf), 0);
    chk("async_rst_afull", int'(bus.walmost_full), 0);
    model_reset();
    bus.wq2_rptr = '0;
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    bus.winc = 1'b0;
    bus.wovf_clr = 1'b0;
    bus.wq2_rptr = '0;

    // 1: reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    async_reset_pulse();

    // 2: fill from empty
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0);
      if (i == TH) begin
        chk("afull_at_thresh", int'(bus.walmost_full), 1);
        chk("level_at_thresh", int'(bus.wlevel), TH);
      end
    end
    chk("full_wptr", int'(bus.wptr), 24);
    chk("full_flag", int'(bus.wfull), 1);
    chk("full_level", int'(bus.wlevel), DEPTH);
    chk("full_waddr", int'(bus.waddr), 0);

    // 3: overflow while full
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("ovf_set", int'(bus.wovf), 1);
    chk("ovf_wptr_held", int'(bus.wptr), 24);
    cycle(1'b0, 1'b1);
    chk("ovf_cleared", int'(bus.wovf), 0);
    cycle(1'b1, 1'b1);
    chk("ovf_set_wins", int'(bus.wovf), 1);

    // 4: drain release
    rd = 4;
    cycle(1'b0, 1'b1);
    chk("drain_full", int'(bus.wfull), 0);
    chk("drain_level12", int'(bus.wlevel), 12);
    chk("drain_afull12", int'(bus.walmost_full), 1);
    rd = 5;
    cycle(1'b0, 1'b0);
    chk("drain_level11", int'(bus.wlevel), 11);
    chk("drain_afull11", int'(bus.walmost_full), 0);

    // 5: wrap-around with the reader close behind
    for (int i = 0; i < 40; i++) begin
      rd = wr - 1;
      cycle(1'b1, 1'b0);
      chk("wrap_level", int'(bus.wlevel), 2);
      chk("wrap_not_full", int'(bus.wfull), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (rd < wr && $urandom_range(0, 1) == 1) rd++;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // 6: reset mid-burst
    async_reset_pulse();
    repeat (7) cycle(1'b1, 1'b0);
    async_reset_pulse();
    chk("post_rst_waddr", int'(bus.waddr), 0);
    cycle(1'b1, 1'b0);
    chk("post_rst_wptr", int'(bus.wptr), 1);
    cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
